mux_rr_arbiter: RTL and testbench

- Round-robin arbiter sharing one 32-bit downstream port among 7 requesters.
- Drives the 3-bit select of the team's 7-input 32-bit select mux. Adds a req/ready handshake and burst limiting.
- Sits between cache/context-switch agents (save/restore engines, CPU port, debug) and a single shared sink such as a memory or writeback port.

---
 rtl/mux_rr_arbiter_pkg.sv | 22 ++
 rtl/mux_rr_arbiter_if.sv | 34 +++
 rtl/mux_rr_arbiter_mux7.sv | 27 ++
 rtl/mux_rr_arbiter_rr_pick.sv | 38 +++
 rtl/mux_rr_arbiter.sv | 96 +++++++++
 tb/tb_mux_rr_arbiter.sv | 195 +++++++++++++++++++
 6 files changed

// File: rtl/mux_rr_arbiter_pkg.sv
// ============================================================================
// Module   : mux_rr_arbiter_pkg
// Brief    : Shared constants and types for the round-robin mux arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mux_rr_arbiter_pkg;

    localparam int N_REQ = 7;
    localparam int SEL_W = 3;

    typedef logic [SEL_W-1:0] idx_t;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

endpackage

`default_nettype wire

// File: rtl/mux_rr_arbiter_if.sv
// ============================================================================
// Module   : mux_rr_arbiter_if
// Brief    : Requester/downstream bundle for the round-robin mux arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mux_rr_arbiter_if #(
    parameter int DATA_W = 32
);
    logic [mux_rr_arbiter_pkg::N_REQ-1:0]        req;
    logic [mux_rr_arbiter_pkg::N_REQ*DATA_W-1:0] req_data;
    logic [mux_rr_arbiter_pkg::N_REQ-1:0]        grant;
    logic [mux_rr_arbiter_pkg::N_REQ-1:0]        ack;
    mux_rr_arbiter_pkg::idx_t                    select;
    logic                                        out_valid;
    logic [DATA_W-1:0]                           out_data;
    logic                                        out_ready;
    logic                                        busy;

    // Agents and the downstream sink drive the bus as master.
    modport master (
        output req, req_data, out_ready,
        input  grant, ack, select, out_valid, out_data, busy
    );

    // The arbiter serves the bus as slave.
    modport slave (
        input  req, req_data, out_ready,
        output grant, ack, select, out_valid, out_data, busy
    );
endinterface

`default_nettype wire

// File: rtl/mux_rr_arbiter_mux7.sv
// ============================================================================
// Module   : mux7_sel
// Brief    : 7-input select mux; encoding 3'b111 returns zero.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mux7_sel
    import mux_rr_arbiter_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  wire idx_t                      i_sel,
    input  wire logic [N_REQ*DATA_W-1:0]   i_data,
    output logic [DATA_W-1:0]              o_data
);

    always_comb begin
        o_data = '0;
        if (int'(i_sel) < N_REQ) begin
            o_data = i_data[int'(i_sel)*DATA_W +: DATA_W];
        end
    end

endmodule

`default_nettype wire

// File: rtl/mux_rr_arbiter_rr_pick.sv
// ============================================================================
// Module   : rr_pick
// Brief    : Finds the first set request after the pointer, modulo 7.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick
    import mux_rr_arbiter_pkg::*;
(
    input  wire logic [N_REQ-1:0] i_req,
    input  wire idx_t             i_ptr,
    output logic                  o_found,
    output idx_t                  o_idx
);

    logic [7:0] w_req8;
    int         w_pos;

    assign w_req8 = {1'b0, i_req};

    // Scan farthest offset first so the nearest hit is the last one written.
    always_comb begin
        o_found = 1'b0;
        o_idx   = '0;
        w_pos   = 0;
        for (int off = N_REQ; off >= 1; off--) begin
            w_pos = (int'(i_ptr) + off) % N_REQ;
            if (w_req8[w_pos[2:0]]) begin
                o_found = 1'b1;
                o_idx   = idx_t'(w_pos);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/mux_rr_arbiter.sv
// ============================================================================
// Module   : mux_rr_arbiter
// Brief    : 7-way round-robin arbiter with burst limit driving a select mux.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mux_rr_arbiter
    import mux_rr_arbiter_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 4
) (
    input  wire logic        clk,
    input  wire logic        reset_n,
    mux_rr_arbiter_if.slave  bus
);

    localparam logic [7:0] c_MAX  = 8'(MAX_BURST);
    localparam logic [7:0] c_LAST = 8'(MAX_BURST - 1);

    state_t             r_state;
    logic [N_REQ-1:0]   r_grant;
    idx_t               r_select;
    idx_t               r_ptr;
    logic [7:0]         r_beat_cnt;

    logic [7:0]         w_req8;
    logic               w_owner_req;
    logic               w_valid;
    logic               w_beat;
    logic               w_others;
    logic               w_found;
    idx_t               w_pick_idx;

    assign w_req8      = {1'b0, bus.req};
    assign w_owner_req = w_req8[r_select];
    assign w_valid     = (r_state == OWN) && w_owner_req;
    assign w_beat      = w_valid && bus.out_ready;
    assign w_others    = |(bus.req & ~r_grant);

    rr_pick u_pick (
        .i_req   (bus.req),
        .i_ptr   (r_ptr),
        .o_found (w_found),
        .o_idx   (w_pick_idx)
    );

    mux7_sel #(.DATA_W(DATA_W)) u_mux (
        .i_sel  (r_select),
        .i_data (bus.req_data),
        .o_data (bus.out_data)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_grant    <= '0;
            r_select   <= '0;
            r_ptr      <= idx_t'(N_REQ - 1);
            r_beat_cnt <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_state    <= OWN;
                        r_grant    <= 7'b1 << w_pick_idx;
                        r_select   <= w_pick_idx;
                        r_beat_cnt <= '0;
                    end
                end
                OWN: begin
                    // Saturated count keeps the limit armed until a competitor shows up.
                    if (!w_owner_req || (w_beat && (r_beat_cnt >= c_LAST) && w_others)) begin
                        r_state  <= IDLE;
                        r_ptr    <= r_select;
                        r_grant  <= '0;
                        r_select <= '0;
                    end else if (w_beat && (r_beat_cnt != c_MAX)) begin
                        r_beat_cnt <= r_beat_cnt + 8'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.grant     = r_grant;
    assign bus.select    = r_select;
    assign bus.out_valid = w_valid;
    assign bus.ack       = w_beat ? r_grant : '0;
    assign bus.busy      = (r_state == OWN);

endmodule

`default_nettype wire

// File: tb/tb_mux_rr_arbiter.sv
// ============================================================================
// Module   : tb_mux_rr_arbiter
// Brief    : Directed and random checks of mux_rr_arbiter against a reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mux_rr_arbiter;

    localparam int MAXB = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    mux_rr_arbiter_if #(.DATA_W(32)) bus ();

    mux_rr_arbiter #(.DATA_W(32), .MAX_BURST(MAXB)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    logic [31:0] dat [7];
    int n_checks = 0;
    int n_fails  = 0;

    // Reference: current owner (-1 when idle), last owner, beats in this tenure.
    int m_owner = -1;
    int m_ptr   = 6;
    int m_cnt   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [6:0] r, input logic rdy);
        bus.req       = r;
        bus.out_ready = rdy;
        for (int i = 0; i < 7; i++) bus.req_data[i*32 +: 32] = dat[i];
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = 6;
        m_cnt   = 0;
    endtask

    task automatic check_outputs();
        logic [6:0] eg;
        int         es;
        logic       ev;
        eg = (m_owner < 0) ? 7'd0 : 7'(1 << m_owner);
        es = (m_owner < 0) ? 0 : m_owner;
        ev = (m_owner >= 0) && bus.req[es];
        chk("grant",     32'(bus.grant),     32'(eg));
        chk("select",    32'(bus.select),    32'(es));
        chk("out_valid", 32'(bus.out_valid), 32'(ev));
        chk("ack",       32'(bus.ack),       32'((ev && bus.out_ready) ? eg : 7'd0));
        chk("out_data",  bus.out_data,       dat[es]);
        chk("busy",      32'(bus.busy),      32'(m_owner >= 0));
    endtask

    task automatic model_step();
        bit others;
        if (!reset_n) begin
            model_reset();
        end else if (m_owner < 0) begin
            for (int off = 1; off <= 7; off++) begin
                if (bus.req[(m_ptr + off) % 7]) begin
                    m_owner = (m_ptr + off) % 7;
                    m_cnt   = 0;
                    break;
                end
            end
        end else begin
            others = (bus.req & ~7'(1 << m_owner)) != 7'd0;
            if (!bus.req[m_owner]) begin
                m_ptr   = m_owner;
                m_owner = -1;
            end else if (bus.out_ready) begin
                if ((m_cnt + 1 >= MAXB) && others) begin
                    m_ptr   = m_owner;
                    m_owner = -1;
                end else if (m_cnt < MAXB) begin
                    m_cnt++;
                end
            end
        end
    endtask

    task automatic cycle(input int n);
        for (int i = 0; i < n; i++) begin
            #3;
            check_outputs();
            model_step();
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        for (int i = 0; i < 7; i++) dat[i] = 32'h1000_0000 + 32'(i);
        dat[0] = 32'hA5A5_0000;
        drive(7'b0000000, 1'b0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_grant", 32'(bus.grant), 32'd0);
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_busy",  32'(bus.busy), 32'd0);
        reset_n = 1'b1;

        // Single requester 0 streaming.
        drive(7'b0000001, 1'b1);
        cycle(1);
        #3;
        chk("t1_grant", 32'(bus.grant), 32'd1);
        chk("t1_data",  bus.out_data, 32'hA5A5_0000);
        chk("t1_ack",   32'(bus.ack), 32'd1);
        #(-3 + 3);
        cycle(4);

        // Requesters 0 and 6 alternate under the burst limit.
        drive(7'b1000001, 1'b1);
        cycle(24);

        // Owner 3 stalled by the sink, then accepted.
        drive(7'b0000000, 1'b1);
        cycle(2);
        drive(7'b0001000, 1'b0);
        cycle(6);
        drive(7'b0001000, 1'b1);
        cycle(2);

        // Owner 2 withdraws before any beat while 5 waits.
        drive(7'b0000000, 1'b1);
        cycle(2);
        drive(7'b0000100, 1'b0);
        cycle(2);
        drive(7'b0100000, 1'b0);
        cycle(3);

        // Lone requester 4 past the limit, then a competitor appears.
        drive(7'b0000000, 1'b1);
        cycle(2);
        drive(7'b0010000, 1'b1);
        cycle(12);
        drive(7'b0010010, 1'b1);
        cycle(5);

        // Async reset in the middle of owner 5's burst.
        drive(7'b0000000, 1'b1);
        cycle(2);
        drive(7'b0100000, 1'b1);
        cycle(3);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_grant", 32'(bus.grant), 32'd0);
        chk("arst_valid", 32'(bus.out_valid), 32'd0);
        chk("arst_ack",   32'(bus.ack), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        drive(7'b1000001, 1'b1);
        cycle(3);
        chk("post_rst_owner0", 32'(bus.select), 32'd0);
        cycle(6);

        // Random traffic.
        for (int t = 0; t < 3000; t++) begin
            logic [6:0] r;
            r = bus.req;
            for (int i = 0; i < 7; i++) begin
                if (r[i]) r[i] = ($urandom_range(0, 7) != 0);
                else      r[i] = ($urandom_range(0, 3) == 0);
                dat[i] = $urandom;
            end
            drive(r, $urandom_range(0, 3) != 0);
            cycle(1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

`default_nettype wire
